counter_bank: RTL and testbench
===============================

# counter_bank

Parametrised bank of `CHANNELS` independent up-counters, each `WIDTH` bits wide. One channel is selected per cycle and counts through its own programmable prescaler. Each channel has its own wrap/saturate mode and a one-cycle wrap pulse. It generalises the two-output selectable counter (`Output0` every cycle, `Output1` every 4 cycles) into a configurable N-channel block for counting and timing use across the datapath.

## Interface
- `WIDTH`, 64: counter width per channel.
- `CHANNELS`, 4: number of channels; must be ≥ 2.
- `DIV_W`, 8: prescaler divisor width.
- `SEL_W`, `$clog2(CHANNELS)`: select width; derived, do not override.

- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `En`  in  1  global count enable.
- `Slt`  in  `SEL_W`  selected channel index.
- `Clr`  in  `CHANNELS`  per-channel synchronous clear of count and prescaler.
- `Cfg_we`  in  1  configuration write strobe.
- `Cfg_ch`  in  `SEL_W`  channel addressed by the write.
- `Cfg_div`  in  `DIV_W`  new divisor; 0 is treated as 1.
- `Cfg_sat`  in  1  new mode: 1 = saturate, 0 = wrap.
- `Count`  out  `CHANNELS*WIDTH`  channel c occupies bits `[c*WIDTH +: WIDTH]`; registered.
- `Wrap`  out  `CHANNELS`  one-cycle pulse per channel on wrap; registered.

## Operation
- **Per-channel state:** `count[WIDTH]`, `pre[DIV_W]`, `div[DIV_W]`, `sat`.
- **Reset values:**
  - `count` = 0 and `pre` = 0 for all channels.
  - `div` = 1 for channel 0; `div` = 4 for every other channel.
  - `sat` = 0; `Wrap` = 0.
- **Qualifying cycle** for channel c: `En`=1 and `Slt`==c. An out-of-range `Slt` (non-power-of-two `CHANNELS`) qualifies no channel.
- **Prescaler:**
  - On a qualifying cycle, if `pre` == effective divisor − 1, it is a tick: `pre` ← 0.
  - Otherwise `pre` ← `pre`+1.
  - Non-selected channels hold `pre` (no loss of phase).
- **Tick behaviour:**
  - Normal: `count` ← `count`+1.
  - If `count` is all-ones and `sat`=0: `count` ← 0 and `Wrap[c]` asserts for exactly the next cycle.
  - If `count` is all-ones and `sat`=1: `count` holds and no `Wrap`.
- **`Clr[c]`:** `count` ← 0, `pre` ← 0, and no `Wrap` that cycle. `Clr` has top priority over ticks; `div` and `sat` are unaffected.
- **Config write** (`Cfg_we`=1, valid `Cfg_ch`):
  - `div` and `sat` of `Cfg_ch` update on the edge.
  - That channel's `pre` ← 0.
  - A tick due on the same edge still occurs, evaluated with the old `div`/`sat`.
  - An out-of-range `Cfg_ch` is ignored.
- **Priority per channel:** Reset > `Clr` > config prescaler clear > prescaler advance. The count increment from a same-edge tick is kept unless `Clr` is asserted.

## Timing
- Count latency is one edge: a tick on edge k is visible on `Count` after edge k.
- With divisor 1, a continuously selected channel advances every cycle.
- With divisor d, the first increment comes on the d-th qualifying edge after reset, clear or config write.
- `Wrap[c]` is high for the single cycle following the wrapping edge, coincident with `count`=0.
- An asynchronous `Reset` mid-count forces all outputs to their reset values without waiting for `Clk`. Release is sampled on the next edge.
- There is no combinational path from any input to `Count` or `Wrap`.

## Structure
- **Package `counter_bank_pkg`:**
  - Function `reset_div(c)` returning 1 for c=0 and 4 otherwise.
  - Constant `DIV_ONE`.
  - Function `eff_div(d)` mapping 0→1.
- **Sub-module `counter_channel`:**
  - Holds `count`/`pre`/`div`/`sat`/`wrap` for one channel.
  - Inputs: `qual`, `clr`, `cfg_we`, `cfg_div`, `cfg_sat`.
  - Instantiated `CHANNELS` times by a generate loop; the top level only decodes `Slt`/`Cfg_ch` and packs `Count`.

## Test plan
- **Selection and divisors:** Reset, `En`=1, `Slt`=0 for 8 cycles, then `Slt`=1 for 48 cycles → channel 0 = 8 and channel 1 = 12; other channels = 0.
- **Config write:** `Cfg_we`, ch2, `div`=3, then `Slt`=2 for 9 cycles → channel 2 = 3; `Slt`=0 in between does not disturb ch2 phase.
- **Wrap vs saturate:** `WIDTH`=8, ch0 `div`=1.
  - Wrap mode, 256 cycles → count=0, `Wrap[0]` high exactly one cycle.
  - Then `sat`=1, 300 cycles → count holds 255, `Wrap[0]` never asserts.
- **`Clr` priority:** `Clr[1]` asserted on the same edge as a ch1 tick → ch1 = 0, `pre`=0, no `Wrap`.
- **Asynchronous reset:** drive `Reset` high mid-cycle while counting → `Count` and `Wrap` go to 0 before the next `Clk` edge; divisors return to 1/4/4/4.
- **Out-of-range and divisor-zero:** With `CHANNELS`=3, `Slt`=3 for 10 cycles → no count changes. Separately, a `Cfg_div`=0 write behaves as divisor 1.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// rtl/counter_bank_pkg.sv - shared constants and helpers for the counter bank
package counter_bank_pkg;

  localparam int DIV_ONE = 1;

  // Channel 0 counts every selected cycle out of reset; the others every fourth.
  function automatic int reset_div(input int c);
    return (c == 0) ? DIV_ONE : 4;
  endfunction

  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'(DIV_ONE) : d;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// rtl/counter_channel.sv - one prescaled up-counter with wrap/saturate mode
module counter_channel
  import counter_bank_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int DIV_W   = 8,
  parameter int RST_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qual,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_sat,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [DIV_W-1:0] pre;
  logic [DIV_W-1:0] div;
  logic             sat;
  logic [31:0]      eff;
  logic             tick;
  logic             at_max;

  assign eff    = eff_div(32'(div));
  assign tick   = qual && (32'(pre) == (eff - 32'd1));
  assign at_max = &count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      pre   <= '0;
      div   <= DIV_W'(RST_DIV);
      sat   <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        count <= '0;
        pre   <= '0;
      end else begin
        // A tick on a config-write edge still uses the old div/sat.
        if (tick) begin
          if (!at_max) begin
            count <= count + WIDTH'(1);
          end else if (!sat) begin
            count <= '0;
            wrap  <= 1'b1;
          end
        end
        if (cfg_we) begin
          pre <= '0;
        end else if (qual) begin
          pre <= tick ? '0 : pre + DIV_W'(1);
        end
      end
      if (cfg_we) begin
        div <= cfg_div;
        sat <= cfg_sat;
      end
    end
  end

endmodule

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of selectable prescaled counters
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      En,
  input  logic [SEL_W-1:0]          Slt,
  input  logic [CHANNELS-1:0]       Clr,
  input  logic                      Cfg_we,
  input  logic [SEL_W-1:0]          Cfg_ch,
  input  logic [DIV_W-1:0]          Cfg_div,
  input  logic                      Cfg_sat,
  output logic [CHANNELS*WIDTH-1:0] Count,
  output logic [CHANNELS-1:0]       Wrap
);

  // Out-of-range Slt/Cfg_ch values simply match no channel.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic qual;
    logic we;

    assign qual = En && (Slt == SEL_W'(c));
    assign we   = Cfg_we && (Cfg_ch == SEL_W'(c));

    counter_channel #(
      .WIDTH   (WIDTH),
      .DIV_W   (DIV_W),
      .RST_DIV (reset_div(c))
    ) u_ch (
      .clk     (Clk),
      .rst     (Reset),
      .qual    (qual),
      .clr     (Clr[c]),
      .cfg_we  (we),
      .cfg_div (Cfg_div),
      .cfg_sat (Cfg_sat),
      .count   (Count[c*WIDTH +: WIDTH]),
      .wrap    (Wrap[c])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - self-checking bench for counter_bank (8-bit, 3 channels)
module tb_counter_bank;

  localparam int W  = 8;
  localparam int CH = 3;

  logic          Clk;
  logic          Reset;
  logic          En;
  logic [1:0]    Slt;
  logic [CH-1:0] Clr;
  logic          Cfg_we;
  logic [1:0]    Cfg_ch;
  logic [7:0]    Cfg_div;
  logic          Cfg_sat;
  logic [CH*W-1:0] Count;
  logic [CH-1:0] Wrap;

  counter_bank #(.WIDTH(W), .CHANNELS(CH), .DIV_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Clr(Clr),
    .Cfg_we(Cfg_we), .Cfg_ch(Cfg_ch), .Cfg_div(Cfg_div), .Cfg_sat(Cfg_sat),
    .Count(Count), .Wrap(Wrap)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int nvec = 0;
  int nerr = 0;

  int m_count[CH];
  int m_pre[CH];
  int m_div[CH];
  bit m_sat[CH];
  bit m_wrap[CH];

  typedef struct {
    logic       en;
    logic [1:0] slt;
    logic [2:0] clr;
    logic       we;
    logic [1:0] ch;
    logic [7:0] dv;
    logic       st;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [2:0] ew;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic en, input logic [1:0] slt, input logic [2:0] clr,
                              input logic we, input logic [1:0] ch, input logic [7:0] dv,
                              input logic st, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [2:0] ew);
    vec_t v;
    v.en = en; v.slt = slt; v.clr = clr; v.we = we; v.ch = ch; v.dv = dv; v.st = st;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.ew = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] cnt(input int c);
    return Count[c*W +: W];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_count[c] = 0;
      m_pre[c]   = 0;
      m_div[c]   = (c == 0) ? 1 : 4;
      m_sat[c]   = 1'b0;
      m_wrap[c]  = 1'b0;
    end
  endtask

  task automatic model_step(input logic en, input logic [1:0] slt, input logic [2:0] clr,
                            input logic we, input logic [1:0] ch, input logic [7:0] dv,
                            input logic st);
    for (int c = 0; c < CH; c++) begin
      int  effd;
      bit  q;
      bit  tk;
      bit  wr;
      effd = (m_div[c] == 0) ? 1 : m_div[c];
      q    = en && (int'(slt) == c);
      tk   = q && (m_pre[c] == effd - 1);
      wr   = we && (int'(ch) == c);
      m_wrap[c] = 1'b0;
      if (clr[c]) begin
        m_count[c] = 0;
        m_pre[c]   = 0;
      end else begin
        if (tk) begin
          if (m_count[c] < (1 << W) - 1) m_count[c] = m_count[c] + 1;
          else if (!m_sat[c]) begin
            m_count[c] = 0;
            m_wrap[c]  = 1'b1;
          end
        end
        if (wr) m_pre[c] = 0;
        else if (q) m_pre[c] = tk ? 0 : m_pre[c] + 1;
      end
      if (wr) begin
        m_div[c] = int'(dv);
        m_sat[c] = st;
      end
    end
  endtask

  task automatic check_model();
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("model_count%0d", c), 32'(cnt(c)), 32'(m_count[c]));
      chk($sformatf("model_wrap%0d", c), 32'(Wrap[c]), 32'(m_wrap[c]));
    end
  endtask

  // Called at a falling edge; drives inputs, advances one rising edge, checks at the next fall.
  task automatic step(input logic en, input logic [1:0] slt, input logic [2:0] clr,
                      input logic we, input logic [1:0] ch, input logic [7:0] dv, input logic st);
    En = en; Slt = slt; Clr = clr; Cfg_we = we; Cfg_ch = ch; Cfg_div = dv; Cfg_sat = st;
    @(posedge Clk);
    model_step(en, slt, clr, we, ch, dv, st);
    @(negedge Clk);
    check_model();
  endtask

  task automatic run(input logic [1:0] slt, input int n);
    for (int i = 0; i < n; i++) step(1'b1, slt, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    En = 1'b0; Clr = '0; Cfg_we = 1'b0;
    #1;
    model_reset();
    check_model();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int wraps;

    tbl[0]  = mk(1'b1, 2'd0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 8'd1, 8'd0, 8'd0, 3'b000);
    tbl[1]  = mk(1'b1, 2'd1, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 8'd1, 8'd0, 8'd0, 3'b000);
    tbl[2]  = mk(1'b1, 2'd1, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 8'd1, 8'd0, 8'd0, 3'b000);
    tbl[3]  = mk(1'b1, 2'd1, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 8'd1, 8'd0, 8'd0, 3'b000);
    tbl[4]  = mk(1'b1, 2'd1, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 8'd1, 8'd1, 8'd0, 3'b000);
    tbl[5]  = mk(1'b0, 2'd0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 8'd1, 8'd1, 8'd0, 3'b000);
    tbl[6]  = mk(1'b1, 2'd2, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 8'd1, 8'd1, 8'd0, 3'b000);
    tbl[7]  = mk(1'b1, 2'd0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0, 8'd2, 8'd0, 8'd0, 3'b000);
    tbl[8]  = mk(1'b1, 2'd3, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 8'd2, 8'd0, 8'd0, 3'b000);
    tbl[9]  = mk(1'b1, 2'd1, 3'b000, 1'b1, 2'd1, 8'd0, 1'b0, 8'd2, 8'd0, 8'd0, 3'b000);
    tbl[10] = mk(1'b1, 2'd1, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 8'd2, 8'd1, 8'd0, 3'b000);
    tbl[11] = mk(1'b1, 2'd1, 3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 8'd2, 8'd2, 8'd0, 3'b000);
    tbl[12] = mk(1'b0, 2'd0, 3'b000, 1'b1, 2'd3, 8'd7, 1'b1, 8'd2, 8'd2, 8'd0, 3'b000);

    Reset = 1'b1; En = 1'b0; Slt = '0; Clr = '0;
    Cfg_we = 1'b0; Cfg_ch = '0; Cfg_div = '0; Cfg_sat = 1'b0;
    model_reset();
    #1;
    chk("reset_count", 32'(Count), 32'd0);
    chk("reset_wrap", 32'(Wrap), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].en, tbl[i].slt, tbl[i].clr, tbl[i].we, tbl[i].ch, tbl[i].dv, tbl[i].st);
      chk($sformatf("tbl%0d_c0", i), 32'(cnt(0)), 32'(tbl[i].e0));
      chk($sformatf("tbl%0d_c1", i), 32'(cnt(1)), 32'(tbl[i].e1));
      chk($sformatf("tbl%0d_c2", i), 32'(cnt(2)), 32'(tbl[i].e2));
      chk($sformatf("tbl%0d_wrap", i), 32'(Wrap), 32'(tbl[i].ew));
    end

    do_reset();
    run(2'd0, 8);
    run(2'd1, 48);
    chk("sel_c0", 32'(cnt(0)), 32'd8);
    chk("sel_c1", 32'(cnt(1)), 32'd12);
    chk("sel_c2", 32'(cnt(2)), 32'd0);

    step(1'b0, 2'd0, 3'b000, 1'b1, 2'd2, 8'd3, 1'b0);
    run(2'd2, 4);
    run(2'd0, 2);
    run(2'd2, 5);
    chk("cfg_c2", 32'(cnt(2)), 32'd3);

    run(2'd3, 10);
    chk("oob_c0", 32'(cnt(0)), 32'd10);
    chk("oob_c2", 32'(cnt(2)), 32'd3);

    do_reset();
    wraps = 0;
    for (int i = 0; i < 256; i++) begin
      run(2'd0, 1);
      if (Wrap[0]) wraps++;
    end
    chk("wrap_count", 32'(cnt(0)), 32'd0);
    chk("wrap_pulse_now", 32'(Wrap[0]), 32'd1);
    chk("wrap_pulses", 32'(wraps), 32'd1);
    run(2'd1, 1);
    chk("wrap_pulse_gone", 32'(Wrap[0]), 32'd0);
    step(1'b0, 2'd0, 3'b000, 1'b1, 2'd0, 8'd1, 1'b1);
    wraps = 0;
    for (int i = 0; i < 300; i++) begin
      run(2'd0, 1);
      if (Wrap[0]) wraps++;
    end
    chk("sat_count", 32'(cnt(0)), 32'd255);
    chk("sat_pulses", 32'(wraps), 32'd0);

    do_reset();
    run(2'd1, 3);
    step(1'b1, 2'd1, 3'b010, 1'b0, 2'd0, 8'd0, 1'b0);
    chk("clr_c1", 32'(cnt(1)), 32'd0);
    chk("clr_wrap", 32'(Wrap), 32'd0);
    run(2'd1, 3);
    chk("clr_phase", 32'(cnt(1)), 32'd0);
    run(2'd1, 1);
    chk("clr_phase_tick", 32'(cnt(1)), 32'd1);

    run(2'd0, 5);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_count", 32'(Count), 32'd0);
    chk("async_wrap", 32'(Wrap), 32'd0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    run(2'd1, 3);
    chk("rdiv_c1_pre", 32'(cnt(1)), 32'd0);
    run(2'd1, 1);
    chk("rdiv_c1", 32'(cnt(1)), 32'd1);
    run(2'd0, 1);
    chk("rdiv_c0", 32'(cnt(0)), 32'd1);

    step(1'b0, 2'd0, 3'b000, 1'b1, 2'd2, 8'd0, 1'b0);
    run(2'd2, 3);
    chk("div0_c2", 32'(cnt(2)), 32'd3);

    for (int i = 0; i < 3000; i++) begin
      logic       r_en;
      logic [2:0] r_clr;
      logic       r_we;
      r_en  = ($urandom_range(0, 9) != 0);
      r_clr = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      r_we  = ($urandom_range(0, 15) == 0);
      step(r_en, 2'($urandom_range(0, 3)), r_clr, r_we, 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
